slow_ch_rx: RTL

//  Receive side of the 16-bit slow channel. Accepts halfword beats on the p_channel

---
 rtl/slow_ch_rx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/slow_ch_rx.sv
// slow_ch_rx
// Receive side of the 16-bit slow channel. Halfword beats arrive on the
// p_channel srdy/drdy handshake. Four beats are packed into one 64-bit word.
// Completed or flushed words are queued in a show-ahead FIFO. The consumer
// pops them with o_valid/i_rd.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   p_channel_srdy/drdy    beat handshake (transfer = srdy & drdy)
//   p_channel_disconnect   beat closes the transfer (flushes a partial word)
//   p_channel_data_valid   beat carries a real halfword
//   p_channel_data         halfword; first beat of a word lands in bits [15:0]
//   o_data/o_last/o_nhw    head-of-FIFO entry (data, closes transfer, halfword count)
//   o_valid, i_rd          FIFO non-empty, pop request
//   o_count                FIFO occupancy 0..DEPTH
module slow_ch_rx #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_channel_srdy,
  output logic          p_channel_drdy,
  input  logic          p_channel_disconnect,
  input  logic          p_channel_data_valid,
  input  logic [15:0]   p_channel_data,
  output logic [63:0]   o_data,
  output logic          o_last,
  output logic [2:0]    o_nhw,
  output logic          o_valid,
  input  logic          i_rd,
  output logic [AW:0]   o_count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [1:0]    ptr_r;
  logic [47:0]   asm_r;         // lanes 0..2; lane 3 is completed straight from the input
  logic [67:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          drdy_r;
  logic          valid_r;

  logic          acc_s;
  logic          pop_s;
  logic          push_s;
  logic          push_last_s;
  logic [2:0]    push_nhw_s;
  logic [15:0]   lane_s;
  logic [63:0]   merged_s;
  logic [AW:0]   count_next_s;
  logic [67:0]   head_s;

  assign acc_s = p_channel_srdy & drdy_r;
  assign pop_s = valid_r & i_rd;

  // Merge the incoming halfword into the assembly word at the current lane.
  // Lanes at and above ptr are always zero in asm_r, so a data_valid=0 beat
  // writes zero and lanes >= nhw of a flushed word come out zeroed for free.
  always_comb begin
    lane_s   = p_channel_data_valid ? p_channel_data : 16'd0;
    merged_s = {16'd0, asm_r};
    case (ptr_r)
      2'd0:    merged_s[15:0]  = lane_s;
      2'd1:    merged_s[31:16] = lane_s;
      2'd2:    merged_s[47:32] = lane_s;
      2'd3:    merged_s[63:48] = lane_s;
      default: merged_s = {16'd0, asm_r};
    endcase
  end

  // Decide whether the accepted beat pushes a word and with which tag.
  // A disconnect that does not complete a word is a flush; this also covers
  // ptr==3 with data_valid=0, which flushes the three halfwords held.
  always_comb begin
    push_s      = 1'b0;
    push_last_s = 1'b0;
    push_nhw_s  = 3'd0;
    if (acc_s) begin
      if (p_channel_data_valid && (ptr_r == 2'd3)) begin
        push_s      = 1'b1;
        push_last_s = p_channel_disconnect;
        push_nhw_s  = 3'd4;
      end else if (p_channel_disconnect) begin
        push_s      = 1'b1;
        push_last_s = 1'b1;
        push_nhw_s  = {1'b0, ptr_r} + {2'b00, p_channel_data_valid};
      end else begin
        push_s      = 1'b0;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Next occupancy: +1 on push only, -1 on pop only.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + (AW+1)'(1);
      2'b01:   count_next_s = count_r - (AW+1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Beat assembly: lane pointer and partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= 2'd0;
      asm_r <= 48'd0;
    end else if (acc_s) begin
      if (push_s) begin
        ptr_r <= 2'd0;
        asm_r <= 48'd0;
      end else begin
        ptr_r <= ptr_r + {1'b0, p_channel_data_valid};
        asm_r <= merged_s[47:0];
      end
    end
  end

  // FIFO storage, pointers, occupancy and the registered status flags.
  // drdy/valid are computed from the next count so they depend only on
  // registered state; a pop while full therefore raises drdy one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 68'd0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      drdy_r   <= 1'b1;
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {push_nhw_s, push_last_s, merged_s};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      drdy_r  <= (count_next_s != FULL_CNT);
      valid_r <= (count_next_s != '0);
    end
  end

  assign head_s         = mem_r[rd_ptr_r];
  assign o_data         = head_s[63:0];
  assign o_last         = head_s[64];
  assign o_nhw          = head_s[67:65];
  assign o_valid        = valid_r;
  assign o_count        = count_r;
  assign p_channel_drdy = drdy_r;

endmodule
